// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared types and elaboration-time helpers for the radix-2
//                FFT stage: complex constant type, twiddle generator,
//                rounding and clamping helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    // Complex constant; fields are wide enough for any supported TW_W.
    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    // cos(2*pi*m/64) in Q2.14, m = 0..16 (first quadrant of a 64-point circle).
    function automatic int cos64_q14(input int m);
        case (m)
            0:       return 16384;
            1:       return 16305;
            2:       return 16069;
            3:       return 15679;
            4:       return 15137;
            5:       return 14449;
            6:       return 13623;
            7:       return 12665;
            8:       return 11585;
            9:       return 10394;
            10:      return 9102;
            11:      return 7723;
            12:      return 6270;
            13:      return 4756;
            14:      return 3196;
            15:      return 1606;
            default: return 0;
        endcase
    endfunction

    // Re-scale a Q2.14 value to frac_w fractional bits, rounding half-up.
    function automatic int q14_to(input int v, input int frac_w);
        if (frac_w >= 14)
            return v <<< (frac_w - 14);
        else
            return (v + (1 <<< (13 - frac_w))) >>> (14 - frac_w);
    endfunction

    // Clamp an integer into the signed range of a w-bit word.
    function automatic int sat_int(input int x, input int w);
        int hi;
        int lo;
        hi = (1 <<< (w - 1)) - 1;
        lo = -(1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

    // Twiddle W = exp(-j*pi*k/span), span a power of two up to 32.
    // k = 0 yields exactly (1.0, 0) so that pair passes b through bit-exact.
    function automatic cplx_t tw(input int k, input int span, input int frac_w, input int tw_w);
        cplx_t r;
        int    m;
        int    c;
        int    s;
        m = (k * 32) / span;
        if (m <= 16) begin
            c = cos64_q14(m);
            s = cos64_q14(16 - m);
        end else begin
            c = -cos64_q14(32 - m);
            s = cos64_q14(m - 16);
        end
        r.re = sat_int(q14_to(c, frac_w), tw_w);
        r.im = sat_int(-q14_to(s, frac_w), tw_w);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_r2_butterfly.sv
`default_nettype none
// ============================================================================
//  Module      : fft_r2_butterfly
//  Description : One pipelined radix-2 DIT butterfly with a fixed twiddle.
//                Stage 1 forms W*b (rounded), stage 2 forms a +/- W*b with
//                optional /2 and clamp/wrap, flagging out-of-range results.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_r2_butterfly
    import fft_pkg::*;
#(
    parameter int                       DATA_W   = 16,
    parameter int                       TW_W     = 16,
    parameter int                       FRAC_W   = 14,
    parameter int                       SATURATE = 1,
    parameter logic signed [TW_W-1:0]   TW_RE    = '0,
    parameter logic signed [TW_W-1:0]   TW_IM    = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_en1,
    input  logic                        i_en2,
    input  logic                        i_scale,
    input  logic signed [DATA_W-1:0]    i_a_re,
    input  logic signed [DATA_W-1:0]    i_a_im,
    input  logic signed [DATA_W-1:0]    i_b_re,
    input  logic signed [DATA_W-1:0]    i_b_im,
    output logic signed [DATA_W-1:0]    o_top_re,
    output logic signed [DATA_W-1:0]    o_top_im,
    output logic signed [DATA_W-1:0]    o_bot_re,
    output logic signed [DATA_W-1:0]    o_bot_im,
    output logic                        o_ovf
);

    localparam int c_pw = DATA_W + TW_W + 1;
    localparam int c_sw = DATA_W + 2;
    localparam logic signed [c_pw-1:0] c_half = c_pw'(1) <<< (FRAC_W - 1);
    localparam logic signed [c_sw-1:0] c_max  = c_sw'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [c_sw-1:0] c_min  = ~c_max;

    logic signed [c_pw-1:0]   w_pr_re;
    logic signed [c_pw-1:0]   w_pr_im;
    logic signed [DATA_W:0]   w_wb_re;
    logic signed [DATA_W:0]   w_wb_im;
    logic signed [DATA_W-1:0] r_a_re;
    logic signed [DATA_W-1:0] r_a_im;
    logic signed [DATA_W:0]   r_wb_re;
    logic signed [DATA_W:0]   r_wb_im;
    logic                     r_scale;
    logic signed [c_sw-1:0]   w_sum_re;
    logic signed [c_sw-1:0]   w_sum_im;
    logic signed [c_sw-1:0]   w_dif_re;
    logic signed [c_sw-1:0]   w_dif_im;
    logic [DATA_W:0]          w_fin_tre;
    logic [DATA_W:0]          w_fin_tim;
    logic [DATA_W:0]          w_fin_bre;
    logic [DATA_W:0]          w_fin_bim;

    // Optional halving, then range check; returns {out_of_range, result}.
    function automatic logic [DATA_W:0] round_clip(input logic signed [c_sw-1:0] x, input logic half);
        logic signed [c_sw-1:0] y;
        logic                   o;
        y = half ? ((x + c_sw'(1)) >>> 1) : x;
        o = (y > c_max) || (y < c_min);
        if (!o)
            return {1'b0, DATA_W'(y)};
        else if (SATURATE != 0)
            return {1'b1, (y < 0) ? DATA_W'(c_min) : DATA_W'(c_max)};
        else
            return {1'b1, DATA_W'(y)};
    endfunction

    // Full-precision complex product, rounded half-up back to sample scale.
    assign w_pr_re = c_pw'(i_b_re) * c_pw'(TW_RE) - c_pw'(i_b_im) * c_pw'(TW_IM);
    assign w_pr_im = c_pw'(i_b_re) * c_pw'(TW_IM) + c_pw'(i_b_im) * c_pw'(TW_RE);
    assign w_wb_re = (DATA_W + 1)'((w_pr_re + c_half) >>> FRAC_W);
    assign w_wb_im = (DATA_W + 1)'((w_pr_im + c_half) >>> FRAC_W);

    // Stage 1: capture W*b together with the delayed a operand and scale flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_re  <= '0;
            r_a_im  <= '0;
            r_wb_re <= '0;
            r_wb_im <= '0;
            r_scale <= 1'b0;
        end else if (i_en1) begin
            r_a_re  <= i_a_re;
            r_a_im  <= i_a_im;
            r_wb_re <= w_wb_re;
            r_wb_im <= w_wb_im;
            r_scale <= i_scale;
        end
    end

    assign w_sum_re  = c_sw'(r_a_re) + c_sw'(r_wb_re);
    assign w_sum_im  = c_sw'(r_a_im) + c_sw'(r_wb_im);
    assign w_dif_re  = c_sw'(r_a_re) - c_sw'(r_wb_re);
    assign w_dif_im  = c_sw'(r_a_im) - c_sw'(r_wb_im);
    assign w_fin_tre = round_clip(w_sum_re, r_scale);
    assign w_fin_tim = round_clip(w_sum_im, r_scale);
    assign w_fin_bre = round_clip(w_dif_re, r_scale);
    assign w_fin_bim = round_clip(w_dif_im, r_scale);

    // Stage 2: register butterfly results and the per-butterfly range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_top_re <= '0;
            o_top_im <= '0;
            o_bot_re <= '0;
            o_bot_im <= '0;
            o_ovf    <= 1'b0;
        end else if (i_en2) begin
            o_top_re <= w_fin_tre[DATA_W-1:0];
            o_top_im <= w_fin_tim[DATA_W-1:0];
            o_bot_re <= w_fin_bre[DATA_W-1:0];
            o_bot_im <= w_fin_bim[DATA_W-1:0];
            o_ovf    <= w_fin_tre[DATA_W] | w_fin_tim[DATA_W] | w_fin_bre[DATA_W] | w_fin_bim[DATA_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_r2_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fft_r2_stage
//  Description : Parametrised radix-2 DIT butterfly stage with valid/ready
//                handshake, 2-cycle latency, per-beat /2 scaling and
//                saturation/overflow reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_r2_stage
    import fft_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16,
    parameter int FRAC_W   = 14,
    parameter int N_PTS    = 16,
    parameter int SPAN     = 8,
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_scale,
    input  logic [N_PTS*DATA_W-1:0]   in_re,
    input  logic [N_PTS*DATA_W-1:0]   in_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_PTS*DATA_W-1:0]   out_re,
    output logic [N_PTS*DATA_W-1:0]   out_im,
    output logic                      out_ovf,
    output logic                      ovf_sticky,
    input  logic                      ovf_clr
);

    localparam int c_nbf = N_PTS / 2;

    logic             r_v1;
    logic             r_v2;
    logic             w_en1;
    logic             w_en2;
    logic [c_nbf-1:0] w_ovf;

    // Each stage advances when its output slot is empty or being drained.
    assign w_en2     = !r_v2 || out_ready;
    assign w_en1     = !r_v1 || w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r_v2;
    assign out_ovf   = |w_ovf;

    // Valid pipeline: bubbles enter stage 1 whenever it advances without input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
        end
    end

    // Sticky overflow: clear wins over a same-cycle overflowing transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && out_ovf)
            ovf_sticky <= 1'b1;
    end

    // Butterfly j pairs lane a = g*2*SPAN+k with lane a+SPAN using W^k.
    for (genvar j = 0; j < c_nbf; j++) begin : g_bf
        localparam int    c_k  = j % SPAN;
        localparam int    c_a  = (j / SPAN) * 2 * SPAN + c_k;
        localparam int    c_b  = c_a + SPAN;
        localparam cplx_t c_tw = tw(c_k, SPAN, FRAC_W, TW_W);

        fft_r2_butterfly #(
            .DATA_W   (DATA_W),
            .TW_W     (TW_W),
            .FRAC_W   (FRAC_W),
            .SATURATE (SATURATE),
            .TW_RE    (TW_W'(c_tw.re)),
            .TW_IM    (TW_W'(c_tw.im))
        ) u_bf (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en1    (w_en1 && in_valid),
            .i_en2    (w_en2 && r_v1),
            .i_scale  (in_scale),
            .i_a_re   (in_re[c_a*DATA_W +: DATA_W]),
            .i_a_im   (in_im[c_a*DATA_W +: DATA_W]),
            .i_b_re   (in_re[c_b*DATA_W +: DATA_W]),
            .i_b_im   (in_im[c_b*DATA_W +: DATA_W]),
            .o_top_re (out_re[c_a*DATA_W +: DATA_W]),
            .o_top_im (out_im[c_a*DATA_W +: DATA_W]),
            .o_bot_re (out_re[c_b*DATA_W +: DATA_W]),
            .o_bot_im (out_im[c_b*DATA_W +: DATA_W]),
            .o_ovf    (w_ovf[j])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_r2_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_r2_stage
//  Description : Directed self-checking bench for fft_r2_stage
//                (N_PTS=16, SPAN=8, DATA_W=16, SATURATE=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_r2_stage;

    localparam int DW = 16;
    localparam int NP = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_scale;
    logic [NP*DW-1:0] in_re;
    logic [NP*DW-1:0] in_im;
    logic             out_valid;
    logic             out_ready;
    logic [NP*DW-1:0] out_re;
    logic [NP*DW-1:0] out_im;
    logic             out_ovf;
    logic             ovf_sticky;
    logic             ovf_clr;

    logic signed [DW-1:0] a_re [NP];
    logic signed [DW-1:0] a_im [NP];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_r2_stage #(
        .DATA_W   (16),
        .TW_W     (16),
        .FRAC_W   (14),
        .N_PTS    (16),
        .SPAN     (8),
        .SATURATE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_scale   (in_scale),
        .in_re      (in_re),
        .in_im      (in_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    // Pack lane arrays into the flat input buses.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            in_re[i*DW +: DW] = a_re[i];
            in_im[i*DW +: DW] = a_im[i];
        end
    end

    function automatic logic signed [DW-1:0] o_re(input int i);
        return out_re[i*DW +: DW];
    endfunction

    function automatic logic signed [DW-1:0] o_im(input int i);
        return out_im[i*DW +: DW];
    endfunction

    task automatic clear_lanes();
        for (int i = 0; i < NP; i++) begin
            a_re[i] = '0;
            a_im[i] = '0;
        end
    endtask

    // Present one beat for one cycle; returns at the negedge where it should be on the output.
    task automatic push_beat(input logic sc);
        @(negedge clk);
        in_scale = sc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_scale  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        clear_lanes();
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_re !== '0) begin errors++; $display("FAIL reset_out_re: got %h expected 0", out_re); end
        checks++; if (out_im !== '0) begin errors++; $display("FAIL reset_out_im: got %h expected 0", out_im); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %0b expected 0", out_ovf); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_ovf_sticky: got %0b expected 0", ovf_sticky); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_identity();
        clear_lanes();
        a_re[0] = 16'sd1000;
        a_re[8] = 16'sd500;
        @(negedge clk);
        in_scale = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL identity_latency_early: got %0b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL identity_out_valid: got %0b expected 1", out_valid); end
        checks++; if (o_re(0) !== 16'sd1500) begin errors++; $display("FAIL identity_lane0_re: got %0d expected 1500", o_re(0)); end
        checks++; if (o_re(8) !== 16'sd500) begin errors++; $display("FAIL identity_lane8_re: got %0d expected 500", o_re(8)); end
        checks++; if (out_im !== '0) begin errors++; $display("FAIL identity_im: got %h expected 0", out_im); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL identity_ovf: got %0b expected 0", out_ovf); end
        for (int i = 1; i < NP; i++) begin
            if (i != 8) begin
                checks++; if (o_re(i) !== 16'sd0) begin errors++; $display("FAIL identity_other_lane%0d: got %0d expected 0", i, o_re(i)); end
            end
        end
    endtask

    task automatic test_twiddle();
        clear_lanes();
        a_re[12] = 16'sd1000;   // k=4: W = -j
        a_re[9]  = 16'sd1000;   // k=1: W = (15137,-6270)/16384
        a_re[10] = 16'sd1000;   // k=2: W = (11585,-11585)/16384
        push_beat(1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL twiddle_out_valid: got %0b expected 1", out_valid); end
        checks++; if (o_re(4) !== 16'sd0 || o_im(4) !== -16'sd1000) begin errors++; $display("FAIL twiddle_k4_top: got (%0d,%0d) expected (0,-1000)", o_re(4), o_im(4)); end
        checks++; if (o_re(12) !== 16'sd0 || o_im(12) !== 16'sd1000) begin errors++; $display("FAIL twiddle_k4_bot: got (%0d,%0d) expected (0,1000)", o_re(12), o_im(12)); end
        checks++; if (o_re(1) !== 16'sd924 || o_im(1) !== -16'sd383) begin errors++; $display("FAIL twiddle_k1_top: got (%0d,%0d) expected (924,-383)", o_re(1), o_im(1)); end
        checks++; if (o_re(9) !== -16'sd924 || o_im(9) !== 16'sd383) begin errors++; $display("FAIL twiddle_k1_bot: got (%0d,%0d) expected (-924,383)", o_re(9), o_im(9)); end
        checks++; if (o_re(2) !== 16'sd707 || o_im(2) !== -16'sd707) begin errors++; $display("FAIL twiddle_k2_top: got (%0d,%0d) expected (707,-707)", o_re(2), o_im(2)); end
        checks++; if (o_re(10) !== -16'sd707 || o_im(10) !== 16'sd707) begin errors++; $display("FAIL twiddle_k2_bot: got (%0d,%0d) expected (-707,707)", o_re(10), o_im(10)); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL twiddle_ovf: got %0b expected 0", out_ovf); end
    endtask

    task automatic test_saturation();
        clear_lanes();
        a_re[0] = 16'sd32767;
        a_re[8] = 16'sd32767;
        // Overflowing beat with a simultaneous clear: clear must win.
        push_beat(1'b0);
        checks++; if (o_re(0) !== 16'sd32767) begin errors++; $display("FAIL sat_lane0_re: got %0d expected 32767", o_re(0)); end
        checks++; if (o_re(8) !== 16'sd0) begin errors++; $display("FAIL sat_lane8_re: got %0d expected 0", o_re(8)); end
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sat_out_ovf: got %0b expected 1", out_ovf); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_clear_priority: got %0b expected 0", ovf_sticky); end
        // Same beat again, no clear: sticky sets.
        push_beat(1'b0);
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sat_out_ovf2: got %0b expected 1", out_ovf); end
        @(negedge clk);
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky_set: got %0b expected 1", ovf_sticky); end
        // Scaled beat fits: (65534+1)>>>1 = 32767, (0+1)>>>1 = 0.
        push_beat(1'b1);
        checks++; if (o_re(0) !== 16'sd32767) begin errors++; $display("FAIL sat_scaled_lane0: got %0d expected 32767", o_re(0)); end
        checks++; if (o_re(8) !== 16'sd0) begin errors++; $display("FAIL sat_scaled_lane8: got %0d expected 0", o_re(8)); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL sat_scaled_ovf: got %0b expected 0", out_ovf); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky_hold: got %0b expected 1", ovf_sticky); end
        // Negative clamp.
        a_re[0] = -16'sd32768;
        a_re[8] = -16'sd32768;
        push_beat(1'b0);
        checks++; if (o_re(0) !== -16'sd32768) begin errors++; $display("FAIL sat_neg_lane0: got %0d expected -32768", o_re(0)); end
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf: got %0b expected 1", out_ovf); end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sat_sticky_clear: got %0b expected 0", ovf_sticky); end
    endtask

    task automatic test_back_to_back();
        int               sent = 0;
        int               rcv  = 0;
        logic             prev_stall = 1'b0;
        logic [NP*DW-1:0] hold_re = '0;
        logic [NP*DW-1:0] hold_im = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 6) begin
                clear_lanes();
                a_re[0]  = 16'(100 * (sent + 1));
                a_im[0]  = 16'(sent);
                in_scale = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                checks++; if (out_re !== hold_re || out_im !== hold_im) begin errors++; $display("FAIL b2b_stable cyc%0d: got lane0 %0d expected %0d", cyc, o_re(0), $signed(hold_re[DW-1:0])); end
            end
            if (cyc == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full: got %0b expected 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++; if (o_re(0) !== 16'(100 * (rcv + 1)) || o_im(0) !== 16'(rcv)) begin errors++; $display("FAIL b2b_beat%0d_top: got (%0d,%0d) expected (%0d,%0d)", rcv, o_re(0), o_im(0), 100 * (rcv + 1), rcv); end
                checks++; if (o_re(8) !== 16'(100 * (rcv + 1)) || o_im(8) !== 16'(rcv)) begin errors++; $display("FAIL b2b_beat%0d_bot: got (%0d,%0d) expected (%0d,%0d)", rcv, o_re(8), o_im(8), 100 * (rcv + 1), rcv); end
                rcv++;
            end
            prev_stall = out_valid && !out_ready;
            hold_re    = out_re;
            hold_im    = out_im;
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (rcv != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", rcv); end
    endtask

    task automatic test_reset_mid();
        bit done = 0;
        out_ready = 1'b0;
        clear_lanes();
        @(negedge clk);
        a_re[0]  = 16'sd11;
        in_valid = 1'b1;
        @(negedge clk);
        a_re[0]  = 16'sd22;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %0b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_drop: got %0b expected 0", out_valid); end
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                a_re[0]  = 16'sd777;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                checks++; if (o_re(0) !== 16'sd777) begin errors++; $display("FAIL midrst_first_out: got %0d expected 777", o_re(0)); end
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++; $display("FAIL midrst_timeout: got no output expected one beat");
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_twiddle();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
